// File: rtl/data_mem_pkg.sv
// Shared types for the multi-channel data memory server.
// Channel FSM encoding and the width of the response-latency counter.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    ACK     = 2'd2
  } chan_state_e;

  localparam int LAT_BITS = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, same cycle as request; no grant while en is low.
// Search starts at the channel after the last grantee; pointer resets to channel 0.
module rr_arbiter #(
  parameter int CHANNELS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] req,
  input  logic                en,
  output logic [CHANNELS-1:0] gnt
);

  localparam int PTR_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [PTR_BITS-1:0] ptr_q, ptr_d;
  logic                found;
  int                  idx;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    if (en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        idx = (int'(ptr_q) + i) % CHANNELS;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          ptr_d    = PTR_BITS'((idx + 1) % CHANNELS);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/data_mem_server.sv
// Multi-channel RAM server: one arbitrated access per cycle, ready LATENCY edges after grant.
// 4-phase handshake per channel; load_en preempts all grants for that cycle.
module data_mem_server
  import data_mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 4,
  parameter int LATENCY   = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CHANNELS-1:0]                 read_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  read_address,
  output logic [CHANNELS-1:0]                 read_ready,
  output logic [CHANNELS-1:0][DATA_BITS-1:0]  read_data,
  input  logic [CHANNELS-1:0]                 write_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  write_address,
  input  logic [CHANNELS-1:0][DATA_BITS-1:0]  write_data,
  output logic [CHANNELS-1:0]                 write_ready,
  input  logic                                load_en,
  input  logic [ADDR_BITS-1:0]                load_address,
  input  logic [DATA_BITS-1:0]                load_data,
  output logic                                busy
);

  localparam int                 DEPTH    = 2 ** ADDR_BITS;
  localparam logic [LAT_BITS-1:0] LAT_INIT = LAT_BITS'(LATENCY - 1);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  chan_state_e                       state_q [CHANNELS];
  chan_state_e                       state_d [CHANNELS];
  logic [CHANNELS-1:0][LAT_BITS-1:0]  cnt_q, cnt_d;
  logic [CHANNELS-1:0]                wr_op_q, wr_op_d;
  logic [CHANNELS-1:0][DATA_BITS-1:0] read_data_q, read_data_d;
  logic                               busy_q, busy_d;

  logic [CHANNELS-1:0]  req;
  logic [CHANNELS-1:0]  gnt;
  logic [CHANNELS-1:0]  op_vld;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_waddr;
  logic [DATA_BITS-1:0] ram_wdata;

  // Arbitration only considers idle channels; reset also suppresses grants so no write commits.
  always_comb begin
    req    = '0;
    op_vld = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      req[c]    = (state_q[c] == IDLE) && (read_valid[c] || write_valid[c]);
      op_vld[c] = wr_op_q[c] ? write_valid[c] : read_valid[c];
    end
  end

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .en    (reset && !load_en),
    .gnt   (gnt)
  );

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = load_address;
    ram_wdata = load_data;
    if (load_en) begin
      ram_we = 1'b1;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (gnt[c] && write_valid[c]) begin
          ram_we    = 1'b1;
          ram_waddr = write_address[c];
          ram_wdata = write_data[c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_waddr] <= ram_wdata;
    end
  end

  // Next-state: a grant performs the access immediately; the counter only paces the ready.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c]     = state_q[c];
      cnt_d[c]       = cnt_q[c];
      wr_op_d[c]     = wr_op_q[c];
      read_data_d[c] = read_data_q[c];
      case (state_q[c])
        IDLE: begin
          if (gnt[c]) begin
            wr_op_d[c] = write_valid[c];
            cnt_d[c]   = LAT_INIT;
            state_d[c] = (LATENCY == 1) ? ACK : SERVICE;
            if (!write_valid[c]) begin
              read_data_d[c] = mem_q[read_address[c]];
            end
          end
        end
        SERVICE: begin
          if (!op_vld[c]) begin
            state_d[c] = IDLE;
          end else if (cnt_q[c] == '0) begin
            state_d[c] = ACK;
          end else begin
            cnt_d[c] = cnt_q[c] - LAT_BITS'(1);
          end
        end
        ACK: begin
          if (!op_vld[c]) begin
            state_d[c] = IDLE;
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
    busy_d = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (state_d[c] != IDLE) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= IDLE;
      end
      cnt_q       <= '0;
      wr_op_q     <= '0;
      read_data_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
      end
      cnt_q       <= cnt_d;
      wr_op_q     <= wr_op_d;
      read_data_q <= read_data_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    read_ready  = '0;
    write_ready = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      read_ready[c]  = (state_q[c] == ACK) && !wr_op_q[c];
      write_ready[c] = (state_q[c] == ACK) && wr_op_q[c];
    end
    read_data = read_data_q;
    busy      = busy_q;
  end

endmodule

// File: tb/tb_data_mem_server.sv
// Randomized bench for data_mem_server against a grant-order memory and timing model.
// Each batch predicts grant order, ready timing and read data from the round-robin rules.
module tb_data_mem_server;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int CH  = 4;
  localparam int LAT = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [CH-1:0]          read_valid, read_ready, write_valid, write_ready;
  logic [CH-1:0][AB-1:0]  read_address, write_address;
  logic [CH-1:0][DB-1:0]  read_data, write_data;
  logic                   load_en;
  logic [AB-1:0]          load_address;
  logic [DB-1:0]          load_data;
  logic                   busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [DB-1:0] ref_mem [2**AB];
  int ref_ptr = 0;

  always #5 clk = ~clk;

  data_mem_server #(
    .ADDR_BITS (AB),
    .DATA_BITS (DB),
    .CHANNELS  (CH),
    .LATENCY   (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .read_valid    (read_valid),
    .read_address  (read_address),
    .read_ready    (read_ready),
    .read_data     (read_data),
    .write_valid   (write_valid),
    .write_address (write_address),
    .write_data    (write_data),
    .write_ready   (write_ready),
    .load_en       (load_en),
    .load_address  (load_address),
    .load_data     (load_data),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_rdy"}, 32'(read_ready), 0);
    check({tag, "_wr_rdy"}, 32'(write_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rdata"}, 32'(read_data), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    reset   = 1'b1;
    ref_ptr = 0;
  endtask

  // Issue a set of requests on one edge; optionally hold load_en for 'stall' edges first.
  task automatic run_batch(input logic [CH-1:0] mask, input logic [CH-1:0] wr,
                           input logic [CH-1:0] both, input logic [CH-1:0][AB-1:0] addr,
                           input logic [CH-1:0][DB-1:0] wdat, input int stall,
                           input logic [AB-1:0] ld_addr, input logic [DB-1:0] ld_dat);
    int            exp_t [CH];
    logic [DB-1:0] exp_d [CH];
    int            seen_t [CH];
    logic [CH-1:0] done;
    logic          wrong;
    int            k, t, c, last, start;
    if (stall > 0) ref_mem[ld_addr] = ld_dat;
    k     = 0;
    start = ref_ptr;
    for (int i = 0; i < CH; i++) begin
      c = (start + i) % CH;
      exp_t[c] = 0;
      exp_d[c] = '0;
      seen_t[c] = 0;
      if (mask[c]) begin
        exp_t[c] = 1 + stall + k + LAT;
        k++;
        if (wr[c]) ref_mem[addr[c]] = wdat[c];
        else exp_d[c] = ref_mem[addr[c]];
        ref_ptr = (c + 1) % CH;
      end
    end
    for (int i = 0; i < CH; i++) begin
      read_valid[i]    = mask[i] && (!wr[i] || both[i]);
      write_valid[i]   = mask[i] && wr[i];
      read_address[i]  = addr[i];
      write_address[i] = addr[i];
      write_data[i]    = wdat[i];
    end
    load_en      = (stall > 0);
    load_address = ld_addr;
    load_data    = ld_dat;
    done  = '0;
    wrong = 1'b0;
    t     = 0;
    last  = 0;
    while (t < 60 && !(done == mask && t > last)) begin
      tick();
      t++;
      if (t == stall) load_en = 1'b0;
      if (t <= stall) check("stall_no_ready", 32'({read_ready, write_ready}), 0);
      if (t == stall + 1) check("busy_after_grant", 32'(busy), 1);
      for (int ch = 0; ch < CH; ch++) begin
        if (mask[ch]) begin
          if (done[ch]) begin
            if (t == seen_t[ch] + 1)
              check($sformatf("ready_drop_ch%0d", ch), 32'(read_ready[ch] | write_ready[ch]), 0);
          end else if (wr[ch] ? write_ready[ch] : read_ready[ch]) begin
            done[ch]   = 1'b1;
            seen_t[ch] = t;
            if (t > last) last = t;
            check($sformatf("latency_ch%0d", ch), t, exp_t[ch]);
            if (!wr[ch]) check($sformatf("rdata_ch%0d", ch), 32'(read_data[ch]), 32'(exp_d[ch]));
            read_valid[ch]  = 1'b0;
            write_valid[ch] = 1'b0;
          end
          if (wr[ch] && read_ready[ch]) wrong = 1'b1;
          if (!wr[ch] && write_ready[ch]) wrong = 1'b1;
        end
      end
    end
    load_en     = 1'b0;
    read_valid  = '0;
    write_valid = '0;
    check("batch_done", 32'(done), 32'(mask));
    check("wrong_ready_kind", 32'(wrong), 0);
    check("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    logic [CH-1:0][AB-1:0] a;
    logic [CH-1:0][DB-1:0] d;
    logic [DB-1:0]         v;
    logic [CH-1:0]         m, w;

    reset         = 1'b0;
    read_valid    = '0;
    write_valid   = '0;
    read_address  = '0;
    write_address = '0;
    write_data    = '0;
    load_en       = 1'b0;
    load_address  = '0;
    load_data     = '0;
    do_reset();

    for (int i = 0; i < 2**AB; i++) begin
      load_en      = 1'b1;
      load_address = AB'(i);
      load_data    = (i == 5) ? 8'h2A : DB'($urandom);
      ref_mem[i]   = load_data;
      tick();
    end
    load_en = 1'b0;
    tick();
    check("preload_busy", 32'(busy), 0);

    // Ch0 reads the preloaded 0x2A
    a = '0; d = '0; a[0] = 8'd5;
    run_batch(4'b0001, 4'b0000, 4'b0000, a, d, 0, '0, '0);

    // Ch2 writes 0x77 to addr 9, then ch1 reads it back
    a = '0; d = '0; a[2] = 8'd9; d[2] = 8'h77;
    run_batch(4'b0100, 4'b0100, 4'b0000, a, d, 0, '0, '0);
    a = '0; d = '0; a[1] = 8'd9;
    run_batch(4'b0010, 4'b0000, 4'b0000, a, d, 0, '0, '0);

    // All four channels contend with the pointer at 0
    do_reset();
    for (int i = 0; i < CH; i++) a[i] = AB'($urandom);
    d = '0;
    run_batch(4'b1111, 4'b0000, 4'b0000, a, d, 0, '0, '0);

    // Ch3 presents read and write together: write wins
    a = '0; d = '0; a[3] = 8'd3; d[3] = 8'h11;
    run_batch(4'b1000, 4'b1000, 4'b1000, a, d, 0, '0, '0);
    a = '0; d = '0; a[3] = 8'd3;
    run_batch(4'b1000, 4'b0000, 4'b0000, a, d, 0, '0, '0);

    // Ch1 waits out three cycles of load_en to the address it reads
    a = '0; d = '0; a[1] = 8'd40;
    run_batch(4'b0010, 4'b0000, 4'b0000, a, d, 3, 8'd40, DB'($urandom));

    // Reset while ch0's write is in SERVICE: write persists, no ready pulse
    v = DB'($urandom);
    write_address[0] = 8'd20;
    write_data[0]    = v;
    write_valid[0]   = 1'b1;
    tick();
    ref_mem[20] = v;
    check("svc_busy", 32'(busy), 1);
    check("svc_no_ready", 32'(write_ready[0]), 0);
    reset = 1'b0;
    tick();
    check_idle_outputs("mid_reset");
    write_valid[0] = 1'b0;
    reset          = 1'b1;
    ref_ptr        = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_reset_no_ready", 32'({read_ready, write_ready}), 0);
    end
    a = '0; d = '0; a[2] = 8'd20;
    run_batch(4'b0100, 4'b0000, 4'b0000, a, d, 0, '0, '0);

    // Random contention over a small address window to mix read-after-write ordering
    for (int n = 0; n < 40; n++) begin
      m = CH'($urandom_range(1, 15));
      w = CH'($urandom);
      for (int i = 0; i < CH; i++) begin
        a[i] = AB'($urandom_range(0, 7));
        d[i] = DB'($urandom);
      end
      run_batch(m, w, w & CH'($urandom), a, d,
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0,
                AB'($urandom_range(0, 7)), DB'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_server.md
# data_mem_server

Synthesizable multi-channel data memory that sits directly downstream of the `gpu` data-memory ports and answers its per-channel read/write valid/ready requests from a single-ported RAM. It replaces the behavioural memory model in full-chip simulation and FPGA builds. A round-robin arbiter serializes channel requests at one RAM access per cycle. A parameterized response latency lets benches stress the LSU wait states.

## Interface
Parameters:
- `ADDR_BITS`, 8, address width; RAM depth = 2**ADDR_BITS
- `DATA_BITS`, 8, word width
- `CHANNELS`, 4, number of request channels
- `LATENCY`, 2, cycles from grant edge to `*_ready` rising (legal range 1..15)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low
- `read_valid`  in  [CHANNELS]  per-channel read request
- `read_address`  in  [CHANNELS][ADDR_BITS]  read address, stable while valid
- `read_ready`  out  [CHANNELS]  read response strobe
- `read_data`  out  [CHANNELS][DATA_BITS]  read data, valid while ready high
- `write_valid`  in  [CHANNELS]  per-channel write request
- `write_address`  in  [CHANNELS][ADDR_BITS]  write address
- `write_data`  in  [CHANNELS][DATA_BITS]  write data
- `write_ready`  out  [CHANNELS]  write acknowledge
- `load_en`  in  1  backdoor preload write
- `load_address`  in  ADDR_BITS  preload address
- `load_data`  in  DATA_BITS  preload data
- `busy`  out  1  any channel not IDLE

## Operation
- Per-channel FSM: IDLE → SERVICE → ACK → IDLE.
- IDLE: the channel requests arbitration when `read_valid` or `write_valid` is high. If both are high, the write is serviced.
- Grant: at most one channel per cycle. Round-robin priority starts at the channel after the last grantee. Pointer resets to 0.
- The RAM access executes at the grant edge:
  - A write commits `write_data` to `write_address`.
  - A read captures the RAM word into that channel's `read_data` register.
- SERVICE: a counter is loaded with LATENCY-1 at grant and decrements to 0. Then the FSM moves to ACK. With LATENCY=1, it goes straight to ACK.
- ACK: the matching `read_ready` or `write_ready` is high. `read_data` is held stable. Ready stays high until the requester's valid is sampled low. At that edge ready drops and the channel returns to IDLE (4-phase handshake).
- Requester drops valid during SERVICE (protocol violation): the access has already happened (a write stays committed). The channel returns to IDLE without asserting ready.
- `load_en` high blocks all grants that cycle and writes RAM. Arbitration stalls, and pending channels wait.
- RAM ordering follows grant order. A write granted before a read to the same address is visible to that read.
- RAM contents are not cleared by reset.

## Timing
- After reset low at an edge:
  - all ready outputs are 0
  - all `read_data` are 0
  - `busy` is 0
  - all FSMs are IDLE
  - arbiter pointer is 0
- Reset mid-transaction aborts it. A write already committed stays in RAM.
- Uncontended read: valid seen at edge E0 (grant), ready high from edge E0+LATENCY. The requester drops valid one cycle later, and ready drops at the following edge.
- Minimum per-channel turnaround: LATENCY + 2 cycles.
- Contention with k channels requesting simultaneously: the i-th grantee gets its grant at E0+i, and ready rises at E0+i+LATENCY.
- `busy` is registered. It goes high the cycle after the first grant and low the cycle after the last channel returns to IDLE.

## Structure
- Package `data_mem_pkg`:
  - `chan_state_e` enum (IDLE, SERVICE, ACK)
  - latency counter width constant `LAT_BITS = 4`
- Sub-module `rr_arbiter`:
  - inputs: CHANNELS request vector, enable
  - outputs: one-hot grant
  - internal: registered pointer updated on grant
- Top module holds the RAM array, the per-channel FSM/counter/data registers, and the `busy` register.

## Test plan
- Preload addr 5=0x2A via `load_en`. Ch0 reads addr 5 with LATENCY=2 → `read_ready[0]` rises 2 edges after grant with `read_data[0]`=0x2A, and falls the edge after valid drops.
- Ch2 writes 0x77 to addr 9, then ch1 reads addr 9 → ch1 sees 0x77. Total busy window equals 2×(LATENCY+2) minus overlap.
- All 4 channels assert read at the same edge with pointer=0 → grants in order ch0, ch1, ch2, ch3 on consecutive edges. Each channel's ready is offset by 1 cycle from the previous one.
- Ch3 asserts both read and write to addr 3 (data 0x11) → only `write_ready[3]` pulses. A later read of addr 3 returns 0x11.
- Ch1 requests while `load_en` is held high for 3 cycles → no grant until `load_en` falls. The grant follows on the next edge.
- Assert `reset` low while ch0 is in SERVICE → the next cycle shows all ready=0 and `busy`=0, with no ready pulse. A previously committed write is still readable afterwards.
